// File: rtl/button_debounce_pkg.sv
// Shared types and timing defaults for the pushbutton debouncer and its
// downstream LED blinker (Rate_sel encoding lives here).
package button_debounce_pkg;

  localparam int CLK_HZ                  = 27_000_000;
  localparam int DEFAULT_DEBOUNCE_CYCLES = CLK_HZ / 100;  // 10 ms
  localparam int DEFAULT_LONG_CYCLES     = CLK_HZ;        // 1 s

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  // Blink-rate codes consumed by the LED blinker
  localparam logic [1:0] RATE_1HZ  = 2'd0;
  localparam logic [1:0] RATE_2HZ  = 2'd1;
  localparam logic [1:0] RATE_5HZ  = 2'd2;
  localparam logic [1:0] RATE_10HZ = 2'd3;

  function automatic logic [1:0] next_rate(input logic [1:0] rate);
    return rate + 2'd1;
  endfunction

endpackage

// File: rtl/button_debounce_sync.sv
// Two-flop synchroniser for a single asynchronous input bit.
module sync_2ff (
  input  logic Clock,
  input  logic Reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debounce.sv
// Pushbutton debouncer: accepted press/release/long-press strobes plus a
// blink-rate selector stepped by short presses and reset by a long press.
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic       Button_raw,
  output logic       Button_level,
  output logic       Press_pulse,
  output logic       Release_pulse,
  output logic       Long_pulse,
  output logic [1:0] Rate_sel,
  output state_t     Dbg_state
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int HW = $clog2(LONG_CYCLES) + 1;
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(LONG_CYCLES);

  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_params
    $error("button_debounce: need DEBOUNCE_CYCLES >= 2 and LONG_CYCLES > DEBOUNCE_CYCLES");
  end

  logic          raw_in;
  logic          sample;
  state_t        state, state_d;
  logic [DW-1:0] db_cnt, db_cnt_d;
  logic [HW-1:0] hold_cnt, hold_cnt_d;
  logic          level_d, press_d, release_d, long_d;
  logic [1:0]    rate_d;

  assign raw_in = Button_raw ^ ACTIVE_LOW;

  sync_2ff u_sync (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .d       (raw_in),
    .q       (sample)
  );

  always_comb begin
    state_d    = state;
    db_cnt_d   = db_cnt;
    hold_cnt_d = hold_cnt;
    level_d    = Button_level;
    rate_d     = Rate_sel;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;

    case (state)
      IDLE: begin
        db_cnt_d = '0;
        if (sample) state_d = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (sample == Button_level) begin
          db_cnt_d = '0;
          state_d  = IDLE;
        end else if (db_cnt == DB_LAST) begin
          db_cnt_d   = '0;
          hold_cnt_d = '0;
          state_d    = PRESSED;
          level_d    = 1'b1;
          press_d    = 1'b1;
        end else begin
          db_cnt_d = db_cnt + DW'(1);
        end
      end
      PRESSED: begin
        db_cnt_d = '0;
        if (!sample) state_d = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (sample == Button_level) begin
          db_cnt_d = '0;
          state_d  = PRESSED;
        end else if (db_cnt == DB_LAST) begin
          db_cnt_d  = '0;
          state_d   = IDLE;
          level_d   = 1'b0;
          release_d = 1'b1;
          // A saturated hold count means this press already issued Long_pulse
          if (hold_cnt != HOLD_SAT) rate_d = next_rate(Rate_sel);
        end else begin
          db_cnt_d = db_cnt + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Hold time keeps running through release bounce; a release edge wins over Long_pulse
    if ((state == PRESSED || state == RELEASE_WAIT) && !release_d) begin
      if (hold_cnt == HOLD_LAST) begin
        long_d = 1'b1;
        rate_d = RATE_1HZ;
      end
      if (hold_cnt != HOLD_SAT) hold_cnt_d = hold_cnt + HW'(1);
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state         <= IDLE;
      db_cnt        <= '0;
      hold_cnt      <= '0;
      Button_level  <= 1'b0;
      Press_pulse   <= 1'b0;
      Release_pulse <= 1'b0;
      Long_pulse    <= 1'b0;
      Rate_sel      <= RATE_1HZ;
    end else begin
      state         <= state_d;
      db_cnt        <= db_cnt_d;
      hold_cnt      <= hold_cnt_d;
      Button_level  <= level_d;
      Press_pulse   <= press_d;
      Release_pulse <= release_d;
      Long_pulse    <= long_d;
      Rate_sel      <= rate_d;
    end
  end

  assign Dbg_state = state;

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: directed scenarios plus random pin activity on an
// active-high and an active-low instance, checked every cycle against a model.
module tb_button_debounce;
  import button_debounce_pkg::*;

  localparam int D = 8;
  localparam int L = 40;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic raw_a, raw_b;

  logic       lvl_a, press_a, rel_a, long_a;
  logic [1:0] rate_a;
  state_t     dbg_a;
  logic       lvl_b, press_b, rel_b, long_b;
  logic [1:0] rate_b;
  state_t     dbg_b;

  int n_tests = 0;
  int n_fail  = 0;

  button_debounce #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .ACTIVE_LOW(1'b0)) dut_a (
    .Clock         (clk),
    .Reset_n       (rst_n),
    .Button_raw    (raw_a),
    .Button_level  (lvl_a),
    .Press_pulse   (press_a),
    .Release_pulse (rel_a),
    .Long_pulse    (long_a),
    .Rate_sel      (rate_a),
    .Dbg_state     (dbg_a)
  );

  button_debounce #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .ACTIVE_LOW(1'b1)) dut_b (
    .Clock         (clk),
    .Reset_n       (rst_n),
    .Button_raw    (raw_b),
    .Button_level  (lvl_b),
    .Press_pulse   (press_b),
    .Release_pulse (rel_b),
    .Long_pulse    (long_b),
    .Rate_sel      (rate_b),
    .Dbg_state     (dbg_b)
  );

  // ---------------- reference model ----------------
  // The logic sees the pin two edges late; a level is accepted once the seen
  // input has disagreed with the current level on D+1 consecutive edges.
  logic [1:0] m_pipe [2];
  logic       m_lvl  [2];
  int         m_run  [2];
  int         m_held [2];
  logic       m_long_done [2];
  logic [1:0] m_rate [2];
  logic       e_press [2];
  logic       e_rel   [2];
  logic       e_long  [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pipe[i] = 2'b00;
      m_lvl[i] = 1'b0;
      m_run[i] = 0;
      m_held[i] = 0;
      m_long_done[i] = 1'b0;
      m_rate[i] = 2'd0;
      e_press[i] = 1'b0;
      e_rel[i] = 1'b0;
      e_long[i] = 1'b0;
    end
  endtask

  task automatic model_step(input int i, input logic din);
    logic seen;
    seen = m_pipe[i][1];
    m_pipe[i] = {m_pipe[i][0], din};
    e_press[i] = 1'b0;
    e_rel[i] = 1'b0;
    e_long[i] = 1'b0;
    if (seen != m_lvl[i]) m_run[i]++;
    else m_run[i] = 0;
    if (m_run[i] == D + 1) begin
      m_lvl[i] = seen;
      m_run[i] = 0;
      if (seen) begin
        e_press[i] = 1'b1;
        m_held[i] = 0;
        m_long_done[i] = 1'b0;
      end else begin
        e_rel[i] = 1'b1;
        if (!m_long_done[i]) m_rate[i] = 2'((int'(m_rate[i]) + 1) % 4);
      end
    end else if (m_lvl[i]) begin
      m_held[i]++;
      if (m_held[i] == L && !m_long_done[i]) begin
        e_long[i] = 1'b1;
        m_long_done[i] = 1'b1;
        m_rate[i] = 2'd0;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check_bit("level_a",   lvl_a,   m_lvl[0]);
    check_bit("press_a",   press_a, e_press[0]);
    check_bit("release_a", rel_a,   e_rel[0]);
    check_bit("long_a",    long_a,  e_long[0]);
    check_int("rate_a",    int'(rate_a), int'(m_rate[0]));
    check_bit("level_b",   lvl_b,   m_lvl[1]);
    check_bit("press_b",   press_b, e_press[1]);
    check_bit("release_b", rel_b,   e_rel[1]);
    check_bit("long_b",    long_b,  e_long[1]);
    check_int("rate_b",    int'(rate_b), int'(m_rate[1]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    model_step(0, raw_a);
    model_step(1, ~raw_b);
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  // Outputs must clear immediately while reset is low.
  task automatic apply_reset(input int hold);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    check_int("state_a_reset", int'(dbg_a), int'(IDLE));
    check_int("state_b_reset", int'(dbg_b), int'(IDLE));
    repeat (hold) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // which: 0 press_a, 1 release_a, 2 long_a, 3 press_b. k = edge count, -1 on timeout.
  task automatic wait_pulse(input int which, input int limit, output int k);
    logic hit;
    k = -1;
    for (int n = 1; n <= limit; n++) begin
      cycle();
      case (which)
        0: hit = press_a;
        1: hit = rel_a;
        2: hit = long_a;
        default: hit = press_b;
      endcase
      if (hit === 1'b1) begin
        k = n;
        break;
      end
    end
  endtask

  task automatic short_press_a(input string tag);
    int k;
    raw_a = 1'b1;
    wait_pulse(0, 30, k);
    check_int({tag, "_press_lat"}, k, D + 3);
    run(20 - k);
    raw_a = 1'b0;
    wait_pulse(1, 30, k);
    check_int({tag, "_release_lat"}, k, D + 3);
    run(4);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    int presses;
    raw_a = 1'b0;
    raw_b = 1'b1;
    rst_n = 1'b1;
    #2;
    apply_reset(3);
    run(12);

    // Clean press: pulse on the (D+3)-th edge counting the first sampling edge
    raw_a = 1'b1;
    wait_pulse(0, 30, k);
    check_int("clean_press_lat", k, D + 3);
    check_bit("clean_level", lvl_a, 1'b1);
    check_int("clean_state", int'(dbg_a), int'(PRESSED));
    run(10);
    check_int("clean_rate_held", int'(rate_a), 0);
    raw_a = 1'b0;
    wait_pulse(1, 30, k);
    check_int("clean_release_lat", k, D + 3);
    run(6);

    // Bounce: toggle every 3 cycles for 30 cycles, then hold high
    presses = 0;
    for (int s = 0; s < 10; s++) begin
      raw_a = (s % 2 == 0) ? 1'b1 : 1'b0;
      for (int c = 0; c < 3; c++) begin
        cycle();
        if (press_a === 1'b1) presses++;
      end
    end
    check_int("bounce_no_press", presses, 0);
    raw_a = 1'b1;
    wait_pulse(0, 30, k);
    check_int("bounce_press_lat", k, D + 3);
    run(5);
    raw_a = 1'b0;
    wait_pulse(1, 30, k);
    run(4);

    // Short presses from a fresh reset: Rate_sel 1,2,3,0
    apply_reset(2);
    run(4);
    for (int j = 0; j < 4; j++) begin
      short_press_a("short");
      check_int("short_rate_step", int'(rate_a), (j + 1) % 4);
    end

    // Long press from Rate_sel=2
    short_press_a("pre_long1");
    short_press_a("pre_long2");
    check_int("long_start_rate", int'(rate_a), 2);
    raw_a = 1'b1;
    wait_pulse(0, 30, k);
    check_int("long_press_lat", k, D + 3);
    wait_pulse(2, 60, k);
    check_int("long_after_press", k, L);
    check_int("long_rate_zero", int'(rate_a), 0);
    run(60 - (D + 3) - L);
    raw_a = 1'b0;
    wait_pulse(1, 30, k);
    check_int("long_release_lat", k, D + 3);
    check_int("long_release_rate", int'(rate_a), 0);
    run(6);

    // Reset while PRESSED with Rate_sel=3, button still held
    for (int j = 0; j < 3; j++) short_press_a("pre_reset");
    check_int("pre_reset_rate", int'(rate_a), 3);
    raw_a = 1'b1;
    wait_pulse(0, 30, k);
    run(5);
    apply_reset(2);
    check_int("reset_rate_now", int'(rate_a), 0);
    check_bit("reset_level_now", lvl_a, 1'b0);
    wait_pulse(0, 30, k);
    check_int("repress_after_reset", k, D + 3);
    raw_a = 1'b0;
    wait_pulse(1, 30, k);
    run(4);

    // Active-low instance: pin falling is a press
    raw_b = 1'b0;
    wait_pulse(3, 30, k);
    check_int("active_low_press_lat", k, D + 3);
    check_bit("active_low_level", lvl_b, 1'b1);
    run(6);
    raw_b = 1'b1;
    run(20);

    // Random pin activity, with one reset landing at a random point
    for (int s = 0; s < 40; s++) begin
      int len;
      raw_a = 1'($urandom_range(0, 1));
      raw_b = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) len = int'($urandom_range(30, 70));
      else len = int'($urandom_range(1, 12));
      if (s == 20) apply_reset(int'($urandom_range(1, 3)));
      run(len);
    end
    raw_a = 1'b0;
    raw_b = 1'b1;
    run(30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 The parameter DEBOUNCE_CYCLES SHALL default to 270000 and set the number of consecutive stable samples required to accept a level change (10 ms at 27 MHz).
REQ-002 The parameter LONG_CYCLES SHALL default to 27000000 and set the held-press duration that qualifies as a long press (1 s at 27 MHz).
REQ-003 The parameter ACTIVE_LOW SHALL default to 0; when it is 1, Button_raw SHALL be inverted before synchronisation.
REQ-004 Clock  input  1  system clock, 27 MHz crystal.
REQ-005 Reset_n  input  1  asynchronous active-low reset.
REQ-006 Button_raw  input  1  unsynchronised pushbutton pin.
REQ-007 Button_level  output  1  debounced level, 1 = pressed.
REQ-008 Press_pulse  output  1  single-cycle strobe on an accepted press.
REQ-009 Release_pulse  output  1  single-cycle strobe on an accepted release.
REQ-010 Long_pulse  output  1  single-cycle strobe when a press has been held for LONG_CYCLES.
REQ-011 Rate_sel  output  2  blink-rate select that feeds the LED blinker stage.

Function
REQ-012 Button_raw SHALL pass through a 2-flop synchroniser; the rest of the logic SHALL see only the synchronised sample.
REQ-013 The FSM SHALL have four states: IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT.
REQ-014 IDLE→PRESS_WAIT SHALL occur when the sample is 1; PRESSED→RELEASE_WAIT SHALL occur when the sample is 0.
REQ-015 In PRESS_WAIT and RELEASE_WAIT, a debounce counter SHALL increment on each cycle that the sample differs from Button_level.
REQ-016 If the sample equals Button_level during a wait state, the debounce counter SHALL clear and the FSM SHALL return to IDLE or PRESSED respectively (bounce rejection).
REQ-017 When the debounce counter reaches DEBOUNCE_CYCLES-1 and the sample still differs, the FSM SHALL move to PRESSED or IDLE; on the same edge it SHALL toggle Button_level and assert Press_pulse or Release_pulse for exactly one cycle.
REQ-018 Latency: a clean raw edge SHALL produce its pulse exactly DEBOUNCE_CYCLES+3 clock edges after the first edge that samples the new raw level.
REQ-019 In PRESSED, a hold counter cleared at Press_pulse SHALL increment and saturate; Long_pulse SHALL assert once, on the cycle the hold count reaches LONG_CYCLES-1.
REQ-020 Bounce in RELEASE_WAIT SHALL NOT clear the hold counter.
REQ-021 On Long_pulse, Rate_sel SHALL load 0.
REQ-022 On Release_pulse with no Long_pulse issued for that press, Rate_sel SHALL increment modulo 4 (3→0) on the same edge.
REQ-023 A release following a long press SHALL leave Rate_sel unchanged.
REQ-024 Press_pulse, Release_pulse and Long_pulse SHALL be mutually exclusive in any cycle.
REQ-025 Counter widths SHALL be $clog2 of their terminal value plus one; counters SHALL NOT wrap.
REQ-026 Elaboration SHALL fail if DEBOUNCE_CYCLES < 2 or LONG_CYCLES <= DEBOUNCE_CYCLES.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 While Reset_n is low, the FSM SHALL be IDLE, both counters 0, synchroniser flops 0 (after inversion), Button_level 0, all pulses 0 and Rate_sel 0, all applied asynchronously.
REQ-029 Reset asserted mid-press SHALL discard the press; after deassertion, a still-held button SHALL be re-debounced as a fresh press.
REQ-030 Reset deassertion SHALL be synchronised externally; the block SHALL require no reset-release pulse.

Structure
REQ-031 A shared package SHALL hold the FSM state enum, the default timing constants (CLK_HZ 27000000, DEBOUNCE_CYCLES, LONG_CYCLES) and the Rate_sel encoding (0 = 1 Hz, 1 = 2 Hz, 2 = 5 Hz, 3 = 10 Hz).
REQ-032 The 2-flop synchroniser SHALL be a separate sub-module, sync_2ff, with clock, async active-low reset, d and q ports.

Verification (sim with DEBOUNCE_CYCLES=8, LONG_CYCLES=40)
REQ-033 Clean press: raw 0→1 held → Press_pulse one cycle exactly 11 edges later, Button_level 1; Rate_sel stays 0 until release.
REQ-034 Bounce: raw toggles every 3 cycles for 30 cycles, then holds 1 → no pulse during toggling; a single Press_pulse 11 edges after the final rise.
REQ-035 Short presses: four 20-cycle presses → Rate_sel steps 1, 2, 3, 0 on each Release_pulse.
REQ-036 Long press: starting with Rate_sel=2, hold 60 cycles → Long_pulse once, 40 cycles after Press_pulse; Rate_sel=0; on release, Release_pulse fires and Rate_sel stays 0.
REQ-037 Reset mid-operation: Reset_n low during PRESSED with Rate_sel=3 → all outputs 0 immediately; raw still 1 after release → new Press_pulse 11 edges after deassertion.
REQ-038 ACTIVE_LOW=1: raw 1→0 → Press_pulse 11 edges later; no pulse is generated out of reset while raw idles at 1.
